// File: rtl/usb_ep_pkg.sv
// Shared types for the USB endpoint FIFO bank: host transfer sizes,
// per-port operation results and the size-to-byte-count helper.
package usb_ep_pkg;

    // Host transfer size encoding; the fourth code (3) is illegal
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } h_size_t;

    // Outcome of one port's request in a cycle
    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_DONE = 2'd1,
        OP_ERR  = 2'd2
    } op_result_t;

    // Bytes moved by a host op; 0 flags the illegal size code
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            SZ_W:    size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/usb_ep_fifo_bank_if.sv
// Host and USB request/response signals of the endpoint FIFO bank.
// master = requester side (host bridge / USB engines), slave = FIFO bank.
interface usb_ep_fifo_bank_if #(
    parameter int EPW = 2
);
    logic           h_push;
    logic           h_pop;
    logic [EPW-1:0] h_ep;
    logic [1:0]     h_size;
    logic [31:0]    h_wdata;
    logic [31:0]    h_rdata;
    logic           h_done;
    logic           h_err;

    logic           u_push;
    logic           u_pop;
    logic [EPW-1:0] u_ep;
    logic [7:0]     u_wdata;
    logic [7:0]     u_rdata;
    logic           u_done;
    logic           u_err;

    modport master (
        output h_push, h_pop, h_ep, h_size, h_wdata,
        input  h_rdata, h_done, h_err,
        output u_push, u_pop, u_ep, u_wdata,
        input  u_rdata, u_done, u_err
    );

    modport slave (
        input  h_push, h_pop, h_ep, h_size, h_wdata,
        output h_rdata, h_done, h_err,
        input  u_push, u_pop, u_ep, u_wdata,
        output u_rdata, u_done, u_err
    );
endinterface

// File: rtl/usb_ep_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for one endpoint FIFO. The caller has
// already decided which bytes are accepted; this block only advances state.
module usb_ep_fifo_ctrl #(
    parameter int DEPTH = 64,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [2:0]    push_n,
    input  logic [2:0]    pop_n,
    output logic [PW-1:0] rptr,
    output logic [PW-1:0] wptr,
    output logic [CW-1:0] count
);
    logic [PW-1:0] rptr_reg;
    logic [PW-1:0] wptr_reg;
    logic [CW-1:0] count_reg;

    // Advance pointers modulo DEPTH; flush returns the endpoint to empty
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            rptr_reg  <= rptr_reg + PW'(pop_n);
            wptr_reg  <= wptr_reg + PW'(push_n);
            count_reg <= count_reg + CW'(push_n) - CW'(pop_n);
        end
    end

    assign rptr  = rptr_reg;
    assign wptr  = wptr_reg;
    assign count = count_reg;
endmodule

// File: rtl/usb_ep_fifo_bank.sv
// Multi-endpoint byte FIFO bank between the host bus slave and the USB
// engines. Host side moves 1/2/4 bytes per op, USB side one byte per op.
// Same-endpoint priority is flush > USB > host; acceptance uses the count
// at the start of the cycle. Optional: USB_EP_ERR_LOG_EN adds per-endpoint
// sticky error flags (err_sticky) with a clear input (err_clr).
module usb_ep_fifo_bank
    import usb_ep_pkg::*;
#(
    parameter int  NUM_EP = 4,
    parameter int  DEPTH  = 64,
    localparam int EPW    = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    usb_ep_fifo_bank_if.slave    bus,
    input  logic                 flush,
    input  logic [EPW-1:0]       flush_ep,
    input  logic [EPW-1:0]       stat_ep,
    output logic [CW-1:0]        stat_count,
    output logic [NUM_EP-1:0]    ep_empty,
    output logic [NUM_EP-1:0]    ep_full
`ifdef USB_EP_ERR_LOG_EN
    ,
    output logic [NUM_EP-1:0]    err_sticky,
    input  logic [NUM_EP-1:0]    err_clr
`endif
);
    localparam int NSEL = 1 << EPW;

    logic [PW-1:0]   rptr_a    [NUM_EP];
    logic [PW-1:0]   wptr_a    [NUM_EP];
    logic [CW-1:0]   count_a   [NUM_EP];
    logic [2:0]      push_n    [NUM_EP];
    logic [2:0]      pop_n     [NUM_EP];
    logic [NUM_EP-1:0] ep_flush;
    logic [CW-1:0]   count_pad [NSEL];
    logic [NSEL-1:0] ep_valid;
    logic [7:0]      mem       [NUM_EP][DEPTH];

    logic [CW-1:0] h_cnt, u_cnt;
    logic [2:0]    h_bytes;
    logic          h_base_ok, u_base_ok;
    logic          h_push_ok, h_pop_ok, u_push_ok, u_pop_ok;
    op_result_t    h_res, u_res;
    logic [31:0]   h_rd_word;
    logic [7:0]    u_rd_byte;

    logic [31:0]   h_rdata_reg;
    logic [7:0]    u_rdata_reg;
    logic          h_done_reg, h_err_reg, u_done_reg, u_err_reg;

    // Endpoint-select padding so selects beyond NUM_EP read as invalid/empty
    generate
        for (genvar gi = 0; gi < NSEL; gi++) begin : g_pad
            if (gi < NUM_EP) begin : g_real
                assign count_pad[gi] = count_a[gi];
                assign ep_valid[gi]  = 1'b1;
            end else begin : g_none
                assign count_pad[gi] = '0;
                assign ep_valid[gi]  = 1'b0;
            end
        end
    endgenerate

    assign h_cnt   = count_pad[bus.h_ep];
    assign u_cnt   = count_pad[bus.u_ep];
    assign h_bytes = size_bytes(bus.h_size);

    // USB wins over host; a flush on the same endpoint rejects both
    assign u_base_ok = ep_valid[bus.u_ep] & ~(bus.u_push & bus.u_pop)
                     & ~(flush & (flush_ep == bus.u_ep));
    assign u_push_ok = bus.u_push & u_base_ok & (u_cnt != CW'(DEPTH));
    assign u_pop_ok  = bus.u_pop  & u_base_ok & (u_cnt != '0);

    assign h_base_ok = ep_valid[bus.h_ep] & ~(bus.h_push & bus.h_pop)
                     & (h_bytes != 3'd0) & ~(flush & (flush_ep == bus.h_ep));
    assign h_push_ok = bus.h_push & h_base_ok & ~(u_push_ok & (bus.u_ep == bus.h_ep))
                     & ((CW'(DEPTH) - h_cnt) >= CW'(h_bytes));
    assign h_pop_ok  = bus.h_pop & h_base_ok & ~(u_pop_ok & (bus.u_ep == bus.h_ep))
                     & (h_cnt >= CW'(h_bytes));

    // Classify each port's request for this cycle
    always_comb begin
        h_res = OP_IDLE;
        u_res = OP_IDLE;
        if (h_push_ok || h_pop_ok)       h_res = OP_DONE;
        else if (bus.h_push || bus.h_pop) h_res = OP_ERR;
        if (u_push_ok || u_pop_ok)       u_res = OP_DONE;
        else if (bus.u_push || bus.u_pop) u_res = OP_ERR;
    end

    // One pointer/count controller per endpoint
    generate
        for (genvar gi = 0; gi < NUM_EP; gi++) begin : g_ep
            assign push_n[gi] = (h_push_ok && bus.h_ep == EPW'(gi)) ? h_bytes :
                                (u_push_ok && bus.u_ep == EPW'(gi)) ? 3'd1 : 3'd0;
            assign pop_n[gi]  = (h_pop_ok && bus.h_ep == EPW'(gi)) ? h_bytes :
                                (u_pop_ok && bus.u_ep == EPW'(gi)) ? 3'd1 : 3'd0;
            assign ep_flush[gi] = flush && (flush_ep == EPW'(gi));

            usb_ep_fifo_ctrl #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_ctrl (
                .clk    (clk),
                .rst    (rst),
                .flush  (ep_flush[gi]),
                .push_n (push_n[gi]),
                .pop_n  (pop_n[gi]),
                .rptr   (rptr_a[gi]),
                .wptr   (wptr_a[gi]),
                .count  (count_a[gi])
            );

            assign ep_empty[gi] = (count_a[gi] == '0);
            assign ep_full[gi]  = (count_a[gi] == CW'(DEPTH));
        end
    endgenerate

    // Gather pop bytes at the current read pointers (may straddle the wrap)
    always_comb begin
        h_rd_word = '0;
        u_rd_byte = '0;
        for (int e = 0; e < NUM_EP; e++) begin
            if (bus.h_ep == EPW'(e)) begin
                for (int k = 0; k < 4; k++) begin
                    if (3'(k) < h_bytes)
                        h_rd_word[8*k +: 8] = mem[e][rptr_a[e] + PW'(k)];
                end
            end
            if (bus.u_ep == EPW'(e))
                u_rd_byte = mem[e][rptr_a[e]];
        end
    end

    // Byte storage writes; host and USB never write the same endpoint together
    always_ff @(posedge clk) begin
        for (int e = 0; e < NUM_EP; e++) begin
            if (h_push_ok && bus.h_ep == EPW'(e)) begin
                for (int k = 0; k < 4; k++) begin
                    if (3'(k) < h_bytes)
                        mem[e][wptr_a[e] + PW'(k)] <= bus.h_wdata[8*k +: 8];
                end
            end
            if (u_push_ok && bus.u_ep == EPW'(e))
                mem[e][wptr_a[e]] <= bus.u_wdata;
        end
    end

    // Registered responses; read data holds unless a pop is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            h_rdata_reg <= '0;
            u_rdata_reg <= '0;
            h_done_reg  <= 1'b0;
            h_err_reg   <= 1'b0;
            u_done_reg  <= 1'b0;
            u_err_reg   <= 1'b0;
        end else begin
            h_done_reg <= (h_res == OP_DONE);
            h_err_reg  <= (h_res == OP_ERR);
            u_done_reg <= (u_res == OP_DONE);
            u_err_reg  <= (u_res == OP_ERR);
            if (h_pop_ok) h_rdata_reg <= h_rd_word;
            if (u_pop_ok) u_rdata_reg <= u_rd_byte;
        end
    end

    assign bus.h_rdata = h_rdata_reg;
    assign bus.h_done  = h_done_reg;
    assign bus.h_err   = h_err_reg;
    assign bus.u_rdata = u_rdata_reg;
    assign bus.u_done  = u_done_reg;
    assign bus.u_err   = u_err_reg;
    assign stat_count  = count_pad[stat_ep];

`ifdef USB_EP_ERR_LOG_EN
    logic [NUM_EP-1:0] err_sticky_reg;
    logic [NUM_EP-1:0] err_set;

    generate
        for (genvar gi = 0; gi < NUM_EP; gi++) begin : g_err
            assign err_set[gi] = ((h_res == OP_ERR) && bus.h_ep == EPW'(gi))
                              || ((u_res == OP_ERR) && bus.u_ep == EPW'(gi));
        end
    endgenerate

    // Sticky per-endpoint error log; a new error beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) err_sticky_reg <= '0;
        else     err_sticky_reg <= (err_sticky_reg & ~err_clr) | err_set;
    end

    assign err_sticky = err_sticky_reg;
`endif
endmodule
